johnson_ring_gen: RTL

//  Parametrised WIDTH-bit Johnson (twisted-ring) counter with 2*WIDTH states.

---
 rtl/johnson_pkg.sv | 26 ++
 rtl/johnson_ring_gen_if.sv | 20 ++
 rtl/johnson_legal_chk.sv | 9 +
 rtl/johnson_ring_gen.sv | 77 +++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared helpers for the Johnson ring generator: code-of-index, legality test, index width.
package johnson_pkg;
  localparam int JMAX = 64;
  typedef logic [JMAX-1:0] jcode_t;

  function automatic int idx_w(input int width);
    return $clog2(2*width);
  endfunction

  // Index k <= width fills k ones from the LSB; above width the ones drain from the LSB.
  function automatic jcode_t johnson_code(input int idx, input int width);
    jcode_t c;
    c = '0;
    for (int i = 0; i < JMAX; i++)
      if (i < width) c[i] = (idx <= width) ? (i < idx) : (i >= idx - width);
    return c;
  endfunction

  function automatic bit johnson_legal(input jcode_t q, input int width);
    int n;
    n = 0;
    for (int i = 0; i < JMAX-1; i++)
      if (i < width-1 && q[i] != q[i+1]) n++;
    return (n <= 1);
  endfunction
endpackage

// File: rtl/johnson_ring_gen_if.sv
// Control/status bundle of the Johnson ring generator.
interface johnson_ring_gen_if import johnson_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int IDX_W = idx_w(WIDTH)
);
  logic             en;
  logic             dir;
  logic             sync_clr;
  logic             load;
  logic [IDX_W-1:0] load_idx;
  logic [WIDTH-1:0] q;
  logic [IDX_W-1:0] state_idx;
  logic             wrap;
  logic             illegal;

  modport master (output en, dir, sync_clr, load, load_idx,
                  input  q, state_idx, wrap, illegal);
  modport slave  (input  en, dir, sync_clr, load, load_idx,
                  output q, state_idx, wrap, illegal);
endinterface

// File: rtl/johnson_legal_chk.sv
// Combinational detect: q is legal iff it has at most one adjacent-bit transition.
module johnson_legal_chk import johnson_pkg::*; #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  output logic             illegal
);
  assign illegal = !johnson_legal(jcode_t'(q), WIDTH);
endmodule

// File: rtl/johnson_ring_gen.sv
// WIDTH-bit Johnson counter with tracked binary index, wrap pulse, load and clear.
// Define JOHNSON_SELF_CORRECT_EN to enable illegal-code detection and recovery.
module johnson_ring_gen import johnson_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int IDX_W = idx_w(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  johnson_ring_gen_if.slave  bus
);
  localparam int unsigned    NSTATES = 2*WIDTH;
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NSTATES-1);

  logic [WIDTH-1:0] q_r, q_nx, q_fwd, q_bwd;
  logic [IDX_W-1:0] idx_r, idx_nx;
  logic             wrap_r, wrap_nx, ill_r, ill_nx;
  logic             bad, load_ok;

`ifdef JOHNSON_SELF_CORRECT_EN
  johnson_legal_chk #(.WIDTH(WIDTH)) u_chk (.q(q_r), .illegal(bad));
`else
  assign bad = 1'b0;
`endif

  assign q_fwd   = {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};
  assign q_bwd   = {~q_r[0], q_r[WIDTH-1:1]};
  assign load_ok = 32'(bus.load_idx) < NSTATES;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      q_r    <= '0;
      idx_r  <= '0;
      wrap_r <= 1'b0;
      ill_r  <= 1'b0;
    end else begin
      q_r    <= q_nx;
      idx_r  <= idx_nx;
      wrap_r <= wrap_nx;
      ill_r  <= ill_nx;
    end

  // Recovery > clear > load > step; an out-of-range load holds rather than stepping.
  always_comb begin
    q_nx    = q_r;
    idx_nx  = idx_r;
    wrap_nx = 1'b0;
    ill_nx  = 1'b0;
    if (bad) begin
      q_nx   = '0;
      idx_nx = '0;
      ill_nx = 1'b1;
    end else if (bus.sync_clr) begin
      q_nx   = '0;
      idx_nx = '0;
    end else if (bus.load) begin
      if (load_ok) begin
        q_nx   = WIDTH'(johnson_code(int'(bus.load_idx), WIDTH));
        idx_nx = bus.load_idx;
      end
    end else if (bus.en) begin
      if (!bus.dir) begin
        q_nx    = q_fwd;
        idx_nx  = (idx_r == LAST) ? '0 : idx_r + IDX_W'(1);
        wrap_nx = (idx_r == LAST);
      end else begin
        q_nx    = q_bwd;
        idx_nx  = (idx_r == '0) ? LAST : idx_r - IDX_W'(1);
        wrap_nx = (idx_r == '0);
      end
    end
  end

  assign bus.q         = q_r;
  assign bus.state_idx = idx_r;
  assign bus.wrap      = wrap_r;
  assign bus.illegal   = ill_r;
endmodule
